// File: rtl/lcd_pkg.sv
// lcd_pkg: opcode bits, FSM encoding and DDRAM address helpers for the LCD bus responder
package lcd_pkg;
    localparam int DDRAM_DEPTH = 80;
    localparam int LINE_LEN = 40;
    localparam logic [7:0] SPACE = 8'h20;
    localparam int OP_DDRAM = 7;
    localparam int OP_CGRAM = 6;
    localparam int OP_FUNC = 5;
    localparam int OP_SHIFT = 4;
    localparam int OP_DISP = 3;
    localparam int OP_ENTRY = 2;
    localparam int OP_HOME = 1;
    localparam int OP_CLEAR = 0;
    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_FILL, ST_WAIT} state_t;
    // Line 1 ends at 0x27, line 2 occupies 0x40-0x67; stepping past either end hops to the other line
    function automatic logic [6:0] addr_inc(input logic [6:0] a);
        return a == 7'h27 ? 7'h40 : a == 7'h67 ? 7'h00 : a + 7'd1;
    endfunction
    function automatic logic [6:0] addr_dec(input logic [6:0] a);
        return a == 7'h00 ? 7'h67 : a == 7'h40 ? 7'h27 : a - 7'd1;
    endfunction
    function automatic logic [6:0] addr_to_idx(input logic [6:0] a);
        return a[6] ? 7'(LINE_LEN) + {1'b0, a[5:0]} : {1'b0, a[5:0]};
    endfunction
    function automatic logic addr_mapped(input logic [6:0] a);
        return a[5:0] < 6'(LINE_LEN);
    endfunction
    function automatic logic [5:0] ofs_step(input logic [5:0] o, input logic up);
        return up ? (o == 6'(LINE_LEN - 1) ? 6'd0 : o + 6'd1) : (o == 6'd0 ? 6'(LINE_LEN - 1) : o - 6'd1);
    endfunction
endpackage

// File: rtl/lcd_ddram.sv
// lcd_ddram: 80x8 text buffer with one write port and a registered read-first read port
module lcd_ddram
    import lcd_pkg::*;
(
    input  logic       clk,
    input  logic       we,
    input  logic [6:0] wr_idx,
    input  logic [7:0] wr_data,
    input  logic [6:0] rd_idx,
    output logic [7:0] rd_data
);
    logic [7:0] mem [DDRAM_DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[wr_idx] <= wr_data;
        rd_data <= rd_idx < 7'(DDRAM_DEPTH) ? mem[rd_idx] : SPACE;
    end
endmodule

// File: rtl/lcd_bus_responder.sv
// lcd_bus_responder: HD44780-style write-only 8-bit bus responder holding DDRAM text and display state
module lcd_bus_responder
    import lcd_pkg::*;
#(
    parameter int BUSY_SHORT = 1850,
    parameter int BUSY_LONG  = 76000,
    parameter int CNT_W      = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RS,
    input  logic       E,
    input  logic [7:0] DB,
    output logic       busy,
    output logic       cmd_strobe,
    output logic       cmd_rs,
    output logic [7:0] cmd_data,
    output logic [6:0] addr,
    output logic [5:0] shift_ofs,
    output logic       disp_on,
    output logic       cur_on,
    output logic       blink_on,
    output logic       entry_inc,
    output logic       entry_shift,
    output logic       func_dl,
    output logic       func_n,
    output logic       func_f,
    output logic       busy_err,
    output logic       addr_err,
    input  logic [6:0] rd_idx,
    output logic [7:0] rd_data
);
    logic rs_d1, rs_d2, e_d1, e_d2, e_d3;
    logic [7:0] db_d1, db_d2;
    state_t state;
    logic [CNT_W-1:0] cnt;
    logic [6:0] fill_idx, wr_idx;
    logic [7:0] wr_data;
    logic fall, we, is_long, is_clear;
    always_comb begin
        fall = e_d3 & ~e_d2;
        busy = state != ST_IDLE;
        is_clear = !cmd_rs && cmd_data == 8'h01;
        is_long = !cmd_rs && cmd_data[7:2] == 6'd0;
        we = (state == ST_EXEC && cmd_rs) || state == ST_FILL;
        wr_idx = state == ST_FILL ? fill_idx : addr_to_idx(addr);
        wr_data = state == ST_FILL ? SPACE : cmd_data;
    end
    lcd_ddram u_ddram (
        .clk     (clk),
        .we      (we),
        .wr_idx  (wr_idx),
        .wr_data (wr_data),
        .rd_idx  (rd_idx),
        .rd_data (rd_data)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            {rs_d1, rs_d2, e_d1, e_d2, e_d3} <= '0;
            db_d1 <= 8'h00;
            db_d2 <= 8'h00;
            state <= ST_FILL;
            cnt <= CNT_W'(BUSY_LONG - 1);
            fill_idx <= 7'd0;
            cmd_strobe <= 1'b0;
            cmd_rs <= 1'b0;
            cmd_data <= 8'h00;
            addr <= 7'h00;
            shift_ofs <= 6'd0;
            {disp_on, cur_on, blink_on} <= 3'b000;
            {entry_inc, entry_shift} <= 2'b10;
            {func_dl, func_n, func_f} <= 3'b100;
            busy_err <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            {rs_d1, rs_d2} <= {RS, rs_d1};
            {e_d1, e_d2, e_d3} <= {E, e_d1, e_d2};
            db_d1 <= DB;
            db_d2 <= db_d1;
            cmd_strobe <= 1'b0;
            if (fall && state != ST_IDLE) busy_err <= 1'b1;
            case (state)
                ST_IDLE: if (fall) begin
                    cmd_strobe <= 1'b1;
                    cmd_rs <= rs_d2;
                    cmd_data <= db_d2;
                    if (rs_d2 || db_d2 != 8'h00) state <= ST_EXEC;
                end
                ST_EXEC: begin
                    // EXEC is the first busy cycle, so the remaining wait is two short of the total
                    cnt <= is_long ? CNT_W'(BUSY_LONG - 2) : CNT_W'(BUSY_SHORT - 2);
                    fill_idx <= 7'd0;
                    state <= is_clear ? ST_FILL : ST_WAIT;
                    if (cmd_rs) begin
                        addr <= entry_inc ? addr_inc(addr) : addr_dec(addr);
                        if (entry_shift) shift_ofs <= ofs_step(shift_ofs, entry_inc);
                    end else if (cmd_data[OP_DDRAM]) begin
                        addr <= addr_mapped(cmd_data[6:0]) ? cmd_data[6:0] : 7'h00;
                        if (!addr_mapped(cmd_data[6:0])) addr_err <= 1'b1;
                    end else if (cmd_data[OP_CGRAM]) begin
                    end else if (cmd_data[OP_FUNC]) begin
                        {func_dl, func_n, func_f} <= cmd_data[4:2];
                    end else if (cmd_data[OP_SHIFT]) begin
                        if (cmd_data[3]) shift_ofs <= ofs_step(shift_ofs, cmd_data[2]);
                        else addr <= cmd_data[2] ? addr_inc(addr) : addr_dec(addr);
                    end else if (cmd_data[OP_DISP]) begin
                        {disp_on, cur_on, blink_on} <= cmd_data[2:0];
                    end else if (cmd_data[OP_ENTRY]) begin
                        {entry_inc, entry_shift} <= cmd_data[1:0];
                    end else if (cmd_data[OP_HOME]) begin
                        addr <= 7'h00;
                        shift_ofs <= 6'd0;
                    end else if (cmd_data[OP_CLEAR]) begin
                        addr <= 7'h00;
                        shift_ofs <= 6'd0;
                        entry_inc <= 1'b1;
                    end
                end
                ST_FILL: begin
                    fill_idx <= fill_idx + 7'd1;
                    if (cnt != '0) cnt <= cnt - 1'b1;
                    if (fill_idx == 7'(DDRAM_DEPTH - 1)) state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cnt == '0) state <= ST_IDLE;
                    else cnt <= cnt - 1'b1;
                end
            endcase
        end
    end
endmodule
